serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
Serial bit-stream transmitter that drives the `in` input of the team's serial Mealy sequence-detector FSMs. It loads a parallel pattern word and shifts it out MSB-first, one bit per clock. A programmable repeat count and a one-cycle idle gap separate repetitions. It replaces hand-timed testbench stimulus and serves as the on-chip source end of the same one-bit serial interface.

Parameters:
DATA_W, 16, maximum pattern length in bits
LEN_W, $clog2(DATA_W)+1, width of the length field
REP_W, 4, width of the repeat-count field

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous reset, active-high
start  input  1  request to transmit; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE without done
data_in  input  DATA_W  pattern; bit len_in-1 is sent first
len_in  input  LEN_W  number of bits per pass, 1..DATA_W
rep_in  input  REP_W  additional passes after the first (0 = single pass)
out  output  1  serial bit (registered); connects to detector `in`
out_valid  output  1  high when `out` carries a pattern bit
busy  output  1  high during SHIFT and GAP
done  output  1  one-cycle pulse after the final bit

Behaviour:
- Clocking and reset:
  - One clock `clk`; reset is synchronous and active-high on port `reset`.
  - Reset values: state=IDLE, out=0, out_valid=0, busy=0, done=0.
  - Reset asserted mid-operation returns to IDLE at that edge. No done pulse is produced.
- All outputs are registered.
- States are IDLE, SHIFT, GAP and DONE.
- IDLE:
  - On an edge with start=1 and len_in!=0, latch data_in, len_in and rep_in.
  - If len_in>DATA_W, clamp it to DATA_W.
  - Next state is SHIFT.
  - start with len_in=0 is ignored and the block stays in IDLE.
- SHIFT:
  - Start accepted at edge k → out=data[len-1], out_valid=1, busy=1 from edge k+1.
  - Each subsequent edge presents the next lower bit.
  - The last bit (data[0]) is visible after edge k+len.
  - At the end of a pass with rep_cnt!=0: decrement rep_cnt and go to GAP.
  - At the end of a pass with rep_cnt=0: go to DONE.
- GAP:
  - Lasts exactly one cycle, with out=0, out_valid=0, busy=1.
  - Then returns to SHIFT, restarting at bit len-1.
  - The latched pattern and length are unchanged.
- DONE:
  - Lasts one cycle, with done=1, busy=0, out=0, out_valid=0.
  - Unconditionally returns to IDLE.
  - start during DONE is ignored.
- Total busy cycles = (rep+1)*len + rep.
- start while busy is ignored; latched values are not disturbed by input changes while busy.
- abort:
  - In SHIFT or GAP: next edge enters IDLE with outputs at reset values and no done pulse.
  - In IDLE: abort wins over start (start is not accepted).
  - In DONE: ignored (done still completes).
- Bit counter: LEN_W bits, counts down from len-1 to 0 with no wrap. The repeat counter is REP_W bits and does not underflow.
- out outside out_valid is always 0.

Decomposition:
- Package serial_pattern_pkg holds:
  - state enum (IDLE, SHIFT, GAP, DONE);
  - LEN_W/REP_W helper constants;
  - a clamp-length function.
- No sub-module; the shift register, counters and FSM are all in one module.

Test Plan:
1. reset, then start at edge 0 with len_in=5, data_in=16'b10110, rep_in=0 → out = 1,0,1,1,0 with out_valid=1 in cycles 1–5; done=1 in cycle 6 only; busy=1 in cycles 1–5; IDLE in cycle 7.
2. len_in=3, data_in=3'b101, rep_in=2 → out sequence 1,0,1,gap,1,0,1,gap,1,0,1 with out_valid low only in the two gap cycles; busy high for 11 cycles; one done pulse.
3. start held high for 20 cycles with len_in=4 → exactly one transfer per IDLE visit; second transfer begins the cycle after DONE→IDLE (accepted at IDLE edge).
4. abort asserted during bit 3 of a len 8 pass → IDLE next edge; out=0, out_valid=0, busy=0; done never asserted.
5. reset asserted during GAP with rep_in=3 → all outputs 0 at the next edge; a new start afterward transmits from bit len-1 with a fresh rep count.
6. Boundaries: len_in=0 → no activity. len_in=DATA_W+5 → 16 bits sent. Drive out into the existing Mealy detector with pattern 16'b0110_1011_0001_1101 → detector output matches the golden model cycle-for-cycle.

Source files
------------

// File: rtl/serial_pattern_pkg.sv
// Shared types, widths and helpers for the serial pattern transmitter.
package serial_pattern_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = $clog2(DATA_W) + 1;
  localparam int unsigned REP_W  = 4;
  localparam int unsigned IDX_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Transfer parameters captured when a start is accepted.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
    logic [REP_W-1:0]  rep;
  } cfg_t;

  // Lengths beyond the pattern register are reduced to the full register.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(DATA_W)) begin
      return LEN_W'(DATA_W);
    end
    return len;
  endfunction

endpackage

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched word out MSB-first with
// optional repeats separated by a one-cycle gap. All outputs are registered,
// so each output reflects the state held during the previous cycle.
module serial_pattern_tx
  import serial_pattern_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [REP_W-1:0]  rep_in,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  state_e           state_q;
  state_e           state_d;
  cfg_t             cfg_q;
  cfg_t             cfg_d;
  logic [LEN_W-1:0] bit_cnt_q;
  logic [LEN_W-1:0] bit_cnt_d;
  logic             accept_c;
  logic             last_bit_c;
  logic             out_d;
  logic             out_valid_d;
  logic             busy_d;
  logic             done_d;

  // Abort has priority over start; a zero length request is ignored.
  assign accept_c   = (state_q == IDLE) && start && !abort && (len_in != '0);
  assign last_bit_c = (bit_cnt_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_bit_c) begin
          state_d = (cfg_q.rep != '0) ? GAP : DONE;
        end
      end
      GAP: begin
        state_d = abort ? IDLE : SHIFT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pattern latch, bit counter and repeat counter updates.
  always_comb begin
    cfg_d     = cfg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          cfg_d.data = data_in;
          cfg_d.len  = clamp_len(len_in);
          cfg_d.rep  = rep_in;
          bit_cnt_d  = clamp_len(len_in) - LEN_W'(1);
        end
      end
      SHIFT: begin
        if (!abort) begin
          if (!last_bit_c) begin
            bit_cnt_d = bit_cnt_q - LEN_W'(1);
          end else if (cfg_q.rep != '0) begin
            cfg_d.rep = cfg_q.rep - REP_W'(1);
          end
        end
      end
      GAP: begin
        if (!abort) begin
          bit_cnt_d = cfg_q.len - LEN_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Next output values; an abort clears them at the same edge it leaves SHIFT/GAP.
  always_comb begin
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      SHIFT: begin
        if (!abort) begin
          out_d       = cfg_q.data[bit_cnt_q[IDX_W-1:0]];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      GAP: begin
        if (!abort) begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q     <= '0;
      bit_cnt_q <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      bit_cnt_q <= bit_cnt_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx, including a 1101 Mealy detector
// driven from the serial output.
module tb_serial_pattern_tx;
  import serial_pattern_pkg::*;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] data_in;
  logic [LEN_W-1:0]  len_in;
  logic [REP_W-1:0]  rep_in;
  logic              out;
  logic              out_valid;
  logic              busy;
  logic              done;

  int errors;
  int checks;

  logic [3:0] obs;
  assign obs = {out, out_valid, busy, done};

  serial_pattern_tx dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .data_in  (data_in),
    .len_in   (len_in),
    .rep_in   (rep_in),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overlapping Mealy detector for 1101, fed by the transmitter output.
  logic [1:0] det_st;
  logic       det_c;
  always_ff @(posedge clk) begin
    if (reset) begin
      det_st <= 2'd0;
    end else begin
      case (det_st)
        2'd0:    det_st <= out ? 2'd1 : 2'd0;
        2'd1:    det_st <= out ? 2'd2 : 2'd0;
        2'd2:    det_st <= out ? 2'd2 : 2'd3;
        default: det_st <= out ? 2'd1 : 2'd0;
      endcase
    end
  end
  assign det_c = (det_st == 2'd3) && out;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    data_in = '0; len_in = '0; rep_in = '0;
    tick(); tick();
    checks++;
    if (obs !== 4'b0000) begin
      $display("FAIL reset_held: got %b expected %b", obs, 4'b0000); errors++;
    end
    reset = 1'b0;
    tick();
    checks++;
    if (obs !== 4'b0000) begin
      $display("FAIL reset_release: got %b expected %b", obs, 4'b0000); errors++;
    end
  endtask

  task automatic test_single;
    logic [4:0] sh;
    logic [3:0] exp;
    sh = 5'b10110;
    data_in = 16'b10110; len_in = 5'd5; rep_in = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs !== 4'b0000) begin
      $display("FAIL single_cycle0: got %b expected %b", obs, 4'b0000); errors++;
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = {sh[4], 1'b1, 1'b1, 1'b0};
      sh = sh << 1;
      checks++;
      if (obs !== exp) begin
        $display("FAIL single_bit cycle %0d: got %b expected %b", i, obs, exp); errors++;
      end
    end
    tick();
    checks++;
    if (obs !== 4'b0001) begin
      $display("FAIL single_done: got %b expected %b", obs, 4'b0001); errors++;
    end
    tick();
    checks++;
    if (obs !== 4'b0000) begin
      $display("FAIL single_idle: got %b expected %b", obs, 4'b0000); errors++;
    end
  endtask

  task automatic test_repeat;
    logic [10:0] eo;
    logic [10:0] ev;
    logic [3:0]  exp;
    eo = 11'b10101010101;
    ev = 11'b11101110111;
    data_in = 16'b101; len_in = 5'd3; rep_in = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      exp = {eo[10], ev[10], 1'b1, 1'b0};
      eo = eo << 1;
      ev = ev << 1;
      checks++;
      if (obs !== exp) begin
        $display("FAIL repeat_seq cycle %0d: got %b expected %b", i, obs, exp); errors++;
      end
    end
    tick();
    checks++;
    if (obs !== 4'b0001) begin
      $display("FAIL repeat_done: got %b expected %b", obs, 4'b0001); errors++;
    end
    tick();
    checks++;
    if (obs !== 4'b0000) begin
      $display("FAIL repeat_idle: got %b expected %b", obs, 4'b0000); errors++;
    end
  endtask

  task automatic test_hold_start;
    int         ph;
    logic [3:0] exp;
    logic [3:0] pat;
    data_in = 16'b1001; len_in = 5'd4; rep_in = 4'd0; start = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      tick();
      ph = (c - 1) % 6;
      pat = 4'b1001 << ph;
      if (ph < 4)       exp = {pat[3], 1'b1, 1'b1, 1'b0};
      else if (ph == 4) exp = 4'b0001;
      else              exp = 4'b0000;
      checks++;
      if (obs !== exp) begin
        $display("FAIL hold_start cycle %0d: got %b expected %b", c, obs, exp); errors++;
      end
    end
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (obs !== 4'b0000) begin
      $display("FAIL hold_start_drain: got %b expected %b", obs, 4'b0000); errors++;
    end
  endtask

  task automatic test_abort;
    data_in = 16'h00A5; len_in = 5'd8; rep_in = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    checks++;
    if (obs !== 4'b0110) begin
      $display("FAIL abort_prebit: got %b expected %b", obs, 4'b0110); errors++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (obs !== 4'b0000) begin
      $display("FAIL abort_exit: got %b expected %b", obs, 4'b0000); errors++;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== 4'b0000) begin
        $display("FAIL abort_quiet cycle %0d: got %b expected %b", i, obs, 4'b0000); errors++;
      end
    end
    // Abort and start together in IDLE: no transfer.
    len_in = 5'd4; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 4'b0000) begin
        $display("FAIL abort_idle_wins cycle %0d: got %b expected %b", i, obs, 4'b0000); errors++;
      end
    end
  endtask

  task automatic test_reset_gap;
    logic [6:0] eo;
    logic [6:0] ev;
    logic [3:0] exp;
    data_in = 16'b10; len_in = 5'd2; rep_in = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (obs !== 4'b0010) begin
      $display("FAIL gap_before_reset: got %b expected %b", obs, 4'b0010); errors++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs !== 4'b0000) begin
      $display("FAIL reset_in_gap: got %b expected %b", obs, 4'b0000); errors++;
    end
    tick();
    checks++;
    if (obs !== 4'b0000) begin
      $display("FAIL reset_gap_idle: got %b expected %b", obs, 4'b0000); errors++;
    end
    eo = 7'b1100110;
    ev = 7'b1110111;
    data_in = 16'b110; len_in = 5'd3; rep_in = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp = {eo[6], ev[6], 1'b1, 1'b0};
      eo = eo << 1;
      ev = ev << 1;
      checks++;
      if (obs !== exp) begin
        $display("FAIL post_reset_seq cycle %0d: got %b expected %b", i, obs, exp); errors++;
      end
    end
    tick();
    checks++;
    if (obs !== 4'b0001) begin
      $display("FAIL post_reset_done: got %b expected %b", obs, 4'b0001); errors++;
    end
  endtask

  task automatic test_boundaries;
    logic [15:0] sh;
    logic [3:0]  exp;
    tick();
    data_in = 16'hFFFF; len_in = 5'd0; rep_in = 4'd0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== 4'b0000) begin
        $display("FAIL len_zero cycle %0d: got %b expected %b", i, obs, 4'b0000); errors++;
      end
    end
    start = 1'b0;
    sh = 16'hC3A5;
    data_in = 16'hC3A5; len_in = 5'd21; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = {sh[15], 1'b1, 1'b1, 1'b0};
      sh = sh << 1;
      checks++;
      if (obs !== exp) begin
        $display("FAIL len_clamp cycle %0d: got %b expected %b", i, obs, exp); errors++;
      end
    end
    tick();
    checks++;
    if (obs !== 4'b0001) begin
      $display("FAIL len_clamp_done: got %b expected %b", obs, 4'b0001); errors++;
    end
    tick();
  endtask

  task automatic test_detector;
    logic [15:0] sh;
    logic [3:0]  hist;
    logic        eb;
    logic        ed;
    int          hits;
    sh = 16'b0110_1011_0001_1101;
    hist = 4'b0000;
    hits = 0;
    data_in = 16'b0110_1011_0001_1101; len_in = 5'd16; rep_in = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      eb = (i <= 16) ? sh[15] : 1'b0;
      sh = sh << 1;
      hist = {hist[2:0], eb};
      ed = (hist == 4'b1101);
      if (det_c === 1'b1) hits++;
      checks++;
      if ({out, det_c} !== {eb, ed}) begin
        $display("FAIL detector cycle %0d: got out=%b det=%b expected out=%b det=%b",
                 i, out, det_c, eb, ed);
        errors++;
      end
    end
    checks++;
    if (hits != 2) begin
      $display("FAIL detector_hits: got %0d expected %0d", hits, 2); errors++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_repeat();
    test_hold_start();
    test_abort();
    test_reset_gap();
    test_boundaries();
    test_detector();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
